// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: imem request/response handshake plus the decoded-instruction issue port.
// The master is the fetch unit; the slave side is shared by imem and the control unit.
interface instr_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        branch;
  logic        zero;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, opcode, rs, rt, rd, funct, imm,
           pc_out, pc_plus4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, stall, branch, zero
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, opcode, rs, rt, rd, funct, imm,
           pc_out, pc_plus4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, stall, branch, zero
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS fetch/issue stage: REQ -> WAIT -> ISSUE loop, 3 cycles per instruction minimum.
// Request held until imem_req_ready; issue held while stall; one fetch outstanding at most.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst,
  instr_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, ISSUE} stateT;

  stateT       state;
  stateT       stateNext;
  logic [31:0] pc;
  logic [31:0] pcNext;
  logic [31:0] ir;
  logic [31:0] irNext;
  logic [31:0] pcPlus4;
  logic [31:0] branchTarget;
  logic        reqValid;
  logic        instrValid;

  assign pcPlus4      = pc + 32'd4;
  assign branchTarget = pcPlus4 + {{14{ir[15]}}, ir[15:0], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      ir    <= irNext;
    end
  end

  always_comb begin
    stateNext  = state;
    pcNext     = pc;
    irNext     = ir;
    reqValid   = 1'b0;
    instrValid = 1'b0;
    case (state)
      IDLE: stateNext = REQ;
      REQ: begin
        reqValid = 1'b1;
        if (bus.imem_req_ready) stateNext = WAIT;
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          irNext    = bus.imem_rsp_data;
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        instrValid = 1'b1;
        // branch/zero only matter on the cycle the instruction retires
        if (!bus.stall) begin
          pcNext    = (bus.branch && bus.zero) ? branchTarget : pcPlus4;
          stateNext = REQ;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.imem_req_valid = reqValid;
  assign bus.imem_addr      = reqValid ? pc : 32'd0;
  assign bus.instr_valid    = instrValid;
  assign bus.opcode         = ir[31:26];
  assign bus.rs             = ir[25:21];
  assign bus.rt             = ir[20:16];
  assign bus.rd             = ir[15:11];
  assign bus.funct          = ir[5:0];
  assign bus.imm            = ir[15:0];
  assign bus.pc_out         = pc;
  assign bus.pc_plus4       = pcPlus4;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit; a PC/IR model tracks the expected
// fetch address and decoded fields from the architectural next-PC rule.
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] expPc;
  logic [31:0] prevWord;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chkFields(input string tag, input logic [31:0] w);
    chk({tag, ".opcode"}, 32'(bus.opcode), 32'(w[31:26]));
    chk({tag, ".rs"},     32'(bus.rs),     32'(w[25:21]));
    chk({tag, ".rt"},     32'(bus.rt),     32'(w[20:16]));
    chk({tag, ".rd"},     32'(bus.rd),     32'(w[15:11]));
    chk({tag, ".funct"},  32'(bus.funct),  32'(w[5:0]));
    chk({tag, ".imm"},    32'(bus.imm),    32'(w[15:0]));
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, ".req_valid"},   32'(bus.imem_req_valid), 32'd0);
    chk({tag, ".instr_valid"}, 32'(bus.instr_valid),    32'd0);
    chk({tag, ".addr"},        bus.imem_addr,           32'd0);
    chk({tag, ".pc_out"},      bus.pc_out,              RESET_PC);
    chk({tag, ".pc_plus4"},    bus.pc_plus4,            RESET_PC + 32'd4);
    chkFields(tag, 32'd0);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;
    bus.stall  = 1'b0;
    bus.branch = 1'b0;
    bus.zero   = 1'b0;
    step();
    step();
    chkIdle("reset");
    rst = 1'b0;
    step();
    expPc    = RESET_PC;
    prevWord = 32'd0;
  endtask

  // Entry and exit: one cycle into REQ, sampled 1 time unit after the edge.
  task automatic fetch(input logic [31:0] word, input int rdyDly, input int rspDly,
                       input int stallCyc, input logic br, input logic zr, input bit noise);
    int off;
    chk("req.valid", 32'(bus.imem_req_valid), 32'd1);
    chk("req.addr", bus.imem_addr, expPc);
    chk("req.instr_valid", 32'(bus.instr_valid), 32'd0);
    for (int i = 0; i < rdyDly; i++) begin
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = noise;
      bus.imem_rsp_data  = $urandom;
      bus.branch = 1'($urandom);
      bus.zero   = 1'($urandom);
      step();
      chk("hold.valid", 32'(bus.imem_req_valid), 32'd1);
      chk("hold.addr", bus.imem_addr, expPc);
      chk("hold.pc_out", bus.pc_out, expPc);
      chkFields("hold.ir", prevWord);
    end
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.branch = 1'b0;
    bus.zero   = 1'b0;
    step();
    bus.imem_req_ready = 1'b0;
    chk("wait.req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("wait.instr_valid", 32'(bus.instr_valid), 32'd0);
    for (int j = 0; j < rspDly; j++) begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_req_ready = 1'($urandom);
      step();
      chk("wait.hold", 32'(bus.instr_valid), 32'd0);
    end
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = word;
    step();
    bus.imem_rsp_valid = 1'b0;
    for (int k = 0; k <= stallCyc; k++) begin
      chk("issue.instr_valid", 32'(bus.instr_valid), 32'd1);
      chk("issue.req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("issue.pc_out", bus.pc_out, expPc);
      chk("issue.pc_plus4", bus.pc_plus4, expPc + 32'd4);
      chkFields("issue", word);
      if (k < stallCyc) begin
        bus.stall  = 1'b1;
        bus.branch = 1'($urandom);
        bus.zero   = 1'($urandom);
        bus.imem_rsp_valid = noise;
        bus.imem_rsp_data  = $urandom;
        step();
      end
    end
    bus.stall  = 1'b0;
    bus.branch = br;
    bus.zero   = zr;
    bus.imem_rsp_valid = 1'b0;
    step();
    bus.branch = 1'b0;
    bus.zero   = 1'b0;
    off = int'($signed(word[15:0]));
    expPc = (br && zr) ? expPc + 32'd4 + 32'(off * 4) : expPc + 32'd4;
    prevWord = word;
  endtask

  initial begin
    resetDut();

    // lw at RESET_PC, minimum 3-cycle loop
    fetch(32'h8C22_0004, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("lw.next_addr", bus.imem_addr, 32'h4);

    // Taken branch to 0x40, then backwards branch to 0x3C
    fetch(32'h1000_000E, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    fetch(32'h1000_FFFE, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    chk("br.taken_addr", bus.imem_addr, 32'h3C);
    fetch(32'h1000_FFFE, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    fetch(32'h1000_FFFE, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("br.not_taken_addr", bus.imem_addr, 32'h44);

    // Request not accepted for 5 cycles, with spurious responses in REQ
    fetch($urandom, 5, 1, 0, 1'b0, 1'b0, 1'b1);

    // Stall held 3 cycles in ISSUE
    fetch($urandom, 0, 0, 3, 1'b0, 1'b1, 1'b1);

    // Reset while waiting for a response
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    chk("rstwait.in_wait", 32'(bus.imem_req_valid), 32'd0);
    rst = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    rst = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    chkIdle("rstwait");
    step();
    expPc    = RESET_PC;
    prevWord = 32'd0;
    chk("rstwait.addr", bus.imem_addr, RESET_PC);

    // Wrap: branch from 0 back to 0xFFFF_FFFC, then fall through to 0
    fetch(32'h1000_FFFE, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    chk("wrap.top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    fetch($urandom, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("wrap.zero_addr", bus.imem_addr, 32'h0);

    for (int n = 0; n < 40; n++) begin
      fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
            1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
